delay_unit_arbiter: RTL and testbench
=====================================

DELAY_UNIT_ARBITER -- requirements
Module: delay_unit_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter SETTLE, default 10, giving the shared-unit settle time in clock cycles; the legal range is 1..255.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  request from requester 0 / 1; held high until the matching gnt.
REQ-006 op0_a, op0_b, op1_a, op1_b  input  WIDTH each  requester operands; sampled only at the grant edge.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands taken.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse; result valid.
REQ-009 result  output  WIDTH  captured unit output of the most recent completed operation.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 unit_in1, unit_in2  output  WIDTH each  drive the inputs of the shared delayed gate unit.
REQ-012 unit_out  input  WIDTH  shared unit output; valid no earlier than SETTLE cycles after its inputs change.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SETTLE.
REQ-014 In IDLE, on an edge with any req high, the block SHALL select a winner, load unit_in1/unit_in2 from the winner's op_a/op_b, pulse that requester's gnt for one cycle, load cnt with SETTLE-1, and enter SETTLE.
REQ-015 In SETTLE, cnt SHALL decrement once per edge while it is nonzero.
REQ-016 On the SETTLE edge where cnt==0, the block SHALL register unit_out into result, pulse the winner's done for one cycle, and return to IDLE.
REQ-017 Latency SHALL be exactly SETTLE edges from the grant edge to the done edge; back-to-back throughput SHALL be one operation per SETTLE+1 cycles.
REQ-018 unit_in1/unit_in2 SHALL be held stable from the grant edge until the next grant, so the unit never sees an input change during SETTLE.
REQ-019 Requests SHALL be ignored in SETTLE; a req still high when the FSM is in IDLE SHALL be treated as a new request.
REQ-020 gnt0 and gnt1 SHALL never both be high; done0 and done1 SHALL never both be high.
REQ-021 result SHALL hold its value between captures.
REQ-022 With SETTLE==1, done SHALL follow gnt by exactly one cycle.

Reset
REQ-023 reset SHALL force IDLE, cnt=0, gnt0=gnt1=done0=done1=0, busy=0, result=0, unit_in1=unit_in2=0, and the round-robin pointer to "last served = 1".
REQ-024 reset asserted during SETTLE SHALL abandon the operation without any done pulse; the first edge after reset deasserts SHALL evaluate requests normally.

Configuration
REQ-025 With macro DELAY_UNIT_ARBITER_RR_EN defined, arbitration SHALL be round-robin: when both requests are present, grant the requester not served last; the pointer updates on every grant.
REQ-026 Without DELAY_UNIT_ARBITER_RR_EN, arbitration SHALL be fixed priority with req0 always winning a tie, and no pointer register SHALL exist.

Verification
REQ-027 Single request: SETTLE=10, WIDTH=1, req0=1, op0_a=1, op0_b=1 -> gnt0 pulses, unit_in1=unit_in2=1, done0 pulses 10 edges later, result=1.
REQ-028 Operand change: after a completed 1&1, issue req0 with op0_a=0 -> result=0 at done0, and unit_in1 is stable throughout SETTLE.
REQ-029 Contention with RR_EN: req0 and req1 both held high -> grants go gnt0, gnt1, gnt0, ..., each separated by 11 cycles. Without RR_EN -> gnt0 only while req0 is held.
REQ-030 Reset mid-operation: assert reset 4 cycles after gnt1 -> no done1, busy=0, result=0; a req1 after reset releases completes normally.
REQ-031 Edge timing: SETTLE=1 with back-to-back req0 -> gnt0/done0 alternate, with a new grant every 2 cycles; no gnt is issued while busy=1.

Source files
------------

// File: rtl/delay_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : delay_unit_arbiter
// Brief    : Two-requester arbiter that time-shares one delayed gate unit,
//            holding its inputs for SETTLE cycles before capturing the output.
//            Define DELAY_UNIT_ARBITER_RR_EN for round-robin arbitration;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module delay_unit_arbiter #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] op0_a,
   input  logic [WIDTH-1:0] op0_b,
   input  logic [WIDTH-1:0] op1_a,
   input  logic [WIDTH-1:0] op1_b,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic [WIDTH-1:0] unit_in1,
   output logic [WIDTH-1:0] unit_in2,
   input  logic [WIDTH-1:0] unit_out
);

   localparam logic [0:0] c_IDLE     = 1'b0;
   localparam logic [0:0] c_SETTLE   = 1'b1;
   localparam logic [7:0] c_CNT_LOAD = 8'(SETTLE - 1);

   logic [0:0]       r_state;
   logic [7:0]       r_cnt;
   logic             r_owner;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_done0;
   logic             r_done1;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_in1;
   logic [WIDTH-1:0] r_in2;
   logic             w_any_req;
   logic             w_pick1;

   assign w_any_req = req0 | req1;

`ifdef DELAY_UNIT_ARBITER_RR_EN
   logic r_last;

   // On a tie, serve whichever requester was not served most recently.
   always_comb begin
      w_pick1 = req1;
      if (req0 && req1) begin
         w_pick1 = ~r_last;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (r_state == c_IDLE && w_any_req) begin
         r_last <= w_pick1;
      end
   end
`else
   assign w_pick1 = req1 & ~req0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= c_IDLE;
         r_cnt    <= 8'd0;
         r_owner  <= 1'b0;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_result <= '0;
         r_in1    <= '0;
         r_in2    <= '0;
      end else begin
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  // Unit inputs only move here, so they stay frozen while settling.
                  r_in1   <= w_pick1 ? op1_a : op0_a;
                  r_in2   <= w_pick1 ? op1_b : op0_b;
                  r_gnt0  <= ~w_pick1;
                  r_gnt1  <= w_pick1;
                  r_owner <= w_pick1;
                  r_cnt   <= c_CNT_LOAD;
                  r_state <= c_SETTLE;
               end
            end
            c_SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_result <= unit_out;
                  r_done0  <= ~r_owner;
                  r_done1  <= r_owner;
                  r_state  <= c_IDLE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign done0    = r_done0;
   assign done1    = r_done1;
   assign result   = r_result;
   assign unit_in1 = r_in1;
   assign unit_in2 = r_in2;
   assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_delay_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_unit_arbiter
// Brief    : Directed self-checking bench; instance a uses SETTLE=10/WIDTH=1,
//            instance b uses SETTLE=1/WIDTH=4. Shared unit is a delayed AND.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_unit_arbiter;

   localparam int A_S = 10;
   localparam int B_S = 1;
`ifdef DELAY_UNIT_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic       a_reset, a_req0, a_req1;
   logic [0:0] a_op0_a, a_op0_b, a_op1_a, a_op1_b;
   logic       a_gnt0, a_gnt1, a_done0, a_done1, a_busy;
   logic [0:0] a_result, a_in1, a_in2, a_out;

   logic       b_reset, b_req0, b_req1;
   logic [3:0] b_op0_a, b_op0_b, b_op1_a, b_op1_b;
   logic       b_gnt0, b_gnt1, b_done0, b_done1, b_busy;
   logic [3:0] b_result, b_in1, b_in2, b_out;

   delay_unit_arbiter #(.WIDTH(1), .SETTLE(A_S)) dut_a (
      .clock(clock), .reset(a_reset), .req0(a_req0), .req1(a_req1),
      .op0_a(a_op0_a), .op0_b(a_op0_b), .op1_a(a_op1_a), .op1_b(a_op1_b),
      .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1),
      .result(a_result), .busy(a_busy), .unit_in1(a_in1), .unit_in2(a_in2),
      .unit_out(a_out));

   delay_unit_arbiter #(.WIDTH(4), .SETTLE(B_S)) dut_b (
      .clock(clock), .reset(b_reset), .req0(b_req0), .req1(b_req1),
      .op0_a(b_op0_a), .op0_b(b_op0_b), .op1_a(b_op1_a), .op1_b(b_op1_b),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
      .result(b_result), .busy(b_busy), .unit_in1(b_in1), .unit_in2(b_in2),
      .unit_out(b_out));

   // Delayed AND unit: output is the inverted (wrong) value until the inputs
   // have been stable for SETTLE cycles.
   logic [1:0] a_last = 2'b00;
   int         a_age  = 1000;
   always @(posedge clock) begin
      if ({a_in1, a_in2} != a_last) begin
         a_last <= {a_in1, a_in2};
         a_age  <= 1;
      end else if (a_age < 1000) begin
         a_age <= a_age + 1;
      end
   end
   assign a_out = ((({a_in1, a_in2} != a_last) ? (A_S == 1) : (a_age >= A_S - 1)))
                  ? (a_in1 & a_in2) : ~(a_in1 & a_in2);

   logic [7:0] b_last = 8'h00;
   int         b_age  = 1000;
   always @(posedge clock) begin
      if ({b_in1, b_in2} != b_last) begin
         b_last <= {b_in1, b_in2};
         b_age  <= 1;
      end else if (b_age < 1000) begin
         b_age <= b_age + 1;
      end
   end
   assign b_out = ((({b_in1, b_in2} != b_last) ? (B_S == 1) : (b_age >= B_S - 1)))
                  ? (b_in1 & b_in2) : ~(b_in1 & b_in2);

   function automatic logic sig(input int sel);
      case (sel)
         0:       return a_gnt0;
         1:       return a_gnt1;
         2:       return a_done0;
         3:       return a_done1;
         4:       return b_gnt0;
         default: return b_done0;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clock);
         if (sig(sel) === 1'b1) begin
            seen = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      a_reset = 1'b1; b_reset = 1'b1;
      a_req0 = 1'b0; a_req1 = 1'b0; b_req0 = 1'b0; b_req1 = 1'b0;
      a_op0_a = '0; a_op0_b = '0; a_op1_a = '0; a_op1_b = '0;
      b_op0_a = '0; b_op0_b = '0; b_op1_a = '0; b_op1_b = '0;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({a_gnt0, a_gnt1, a_done0, a_done1, a_busy} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_a_ctrl: got %b want 00000", {a_gnt0, a_gnt1, a_done0, a_done1, a_busy});
      end
      n_cmp++;
      if ({a_result, a_in1, a_in2} !== 3'b0) begin
         n_bad++;
         $display("FAIL reset_a_data: got %b want 000", {a_result, a_in1, a_in2});
      end
      n_cmp++;
      if ({b_gnt0, b_gnt1, b_done0, b_done1, b_busy} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_b_ctrl: got %b want 00000", {b_gnt0, b_gnt1, b_done0, b_done1, b_busy});
      end
      n_cmp++;
      if ({b_result, b_in1, b_in2} !== 12'h0) begin
         n_bad++;
         $display("FAIL reset_b_data: got %h want 000", {b_result, b_in1, b_in2});
      end
      a_reset = 1'b0; b_reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (a_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_no_req: busy got %b want 0", a_busy);
      end
   endtask

   task automatic test_single();
      bit seen;
      int t0;
      a_op0_a = 1'b1; a_op0_b = 1'b1; a_req0 = 1'b1;
      wait_sig(0, 5, seen);
      t0 = cyc;
      a_req0 = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL single_gnt0: gnt0 got 0 want 1 within 5 cycles");
      end
      n_cmp++;
      if ({a_in1, a_in2, a_busy, a_gnt1} !== 4'b1110) begin
         n_bad++;
         $display("FAIL single_grant_state: in1,in2,busy,gnt1 got %b want 1110", {a_in1, a_in2, a_busy, a_gnt1});
      end
      @(negedge clock);
      n_cmp++;
      if (a_gnt0 !== 1'b0) begin
         n_bad++;
         $display("FAIL single_gnt_pulse: gnt0 got %b want 0", a_gnt0);
      end
      wait_sig(2, 20, seen);
      n_cmp++;
      if (!seen || (cyc - t0) != A_S) begin
         n_bad++;
         $display("FAIL single_latency: got seen=%0d lat=%0d want seen=1 lat=%0d", seen, cyc - t0, A_S);
      end
      n_cmp++;
      if ({a_result, a_busy, a_done1} !== 3'b100) begin
         n_bad++;
         $display("FAIL single_done_state: result,busy,done1 got %b want 100", {a_result, a_busy, a_done1});
      end
      @(negedge clock);
      n_cmp++;
      if ({a_done0, a_result} !== 2'b01) begin
         n_bad++;
         $display("FAIL single_hold: done0,result got %b want 01", {a_done0, a_result});
      end
   endtask

   task automatic test_operand_change();
      bit seen;
      bit got;
      bit moved;
      int t0;
      a_op0_a = 1'b0; a_op0_b = 1'b1; a_req0 = 1'b1;
      wait_sig(0, 5, seen);
      t0 = cyc;
      a_req0 = 1'b0;
      n_cmp++;
      if (!seen || a_result !== 1'b1) begin
         n_bad++;
         $display("FAIL opchg_grant: seen=%0d result=%b want seen=1 result=1", seen, a_result);
      end
      got = 1'b0;
      moved = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (a_in1 !== 1'b0 || a_in2 !== 1'b1) moved = 1'b1;
         if (a_done0 === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!got || (cyc - t0) != A_S) begin
         n_bad++;
         $display("FAIL opchg_latency: got done=%0d lat=%0d want done=1 lat=%0d", got, cyc - t0, A_S);
      end
      n_cmp++;
      if (a_result !== 1'b0) begin
         n_bad++;
         $display("FAIL opchg_result: got %b want 0", a_result);
      end
      n_cmp++;
      if (moved) begin
         n_bad++;
         $display("FAIL opchg_stable: unit inputs moved=1 want 0");
      end
   endtask

   task automatic test_contention();
      int  prev;
      bit  own;
      a_reset = 1'b1;
      @(negedge clock);
      a_reset = 1'b0;
      a_op0_a = 1'b1; a_op0_b = 1'b1; a_op1_a = 1'b1; a_op1_b = 1'b0;
      a_req0 = 1'b1; a_req1 = 1'b1;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         own = RR ? k[0] : 1'b0;
         for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (a_gnt0 === 1'b1 || a_gnt1 === 1'b1) break;
         end
         n_cmp++;
         if ({a_gnt0, a_gnt1} !== {~own, own}) begin
            n_bad++;
            $display("FAIL contend_gnt%0d: gnt0,gnt1 got %b want %b", k, {a_gnt0, a_gnt1}, {~own, own});
         end
         if (k > 0) begin
            n_cmp++;
            if ((cyc - prev) != A_S + 1) begin
               n_bad++;
               $display("FAIL contend_spacing%0d: got %0d want %0d", k, cyc - prev, A_S + 1);
            end
         end
         prev = cyc;
         if (k == 3) begin
            a_req0 = 1'b0; a_req1 = 1'b0;
         end
         for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (a_done0 === 1'b1 || a_done1 === 1'b1) break;
         end
         n_cmp++;
         if ({a_done0, a_done1, a_result} !== {~own, own, ~own}) begin
            n_bad++;
            $display("FAIL contend_done%0d: done0,done1,result got %b want %b", k,
                     {a_done0, a_done1, a_result}, {~own, own, ~own});
         end
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      bit bad_done;
      int t0;
      a_op0_a = 1'b1; a_op0_b = 1'b1; a_req0 = 1'b1;
      wait_sig(0, 5, seen);
      a_req0 = 1'b0;
      wait_sig(2, 20, seen);
      n_cmp++;
      if (!seen || a_result !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_setup: done0=%0d result=%b want 1 1", seen, a_result);
      end
      a_op1_a = 1'b1; a_op1_b = 1'b1; a_req1 = 1'b1;
      wait_sig(1, 5, seen);
      a_req1 = 1'b0;
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL rstmid_gnt1: gnt1 got 0 want 1");
      end
      repeat (4) @(negedge clock);
      a_reset = 1'b1;
      bad_done = 1'b0;
      @(negedge clock);
      if (a_done0 !== 1'b0 || a_done1 !== 1'b0) bad_done = 1'b1;
      n_cmp++;
      if ({a_busy, a_result, a_in1, a_in2} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rstmid_state: busy,result,in1,in2 got %b want 0000", {a_busy, a_result, a_in1, a_in2});
      end
      @(negedge clock);
      if (a_done0 !== 1'b0 || a_done1 !== 1'b0) bad_done = 1'b1;
      n_cmp++;
      if (bad_done) begin
         n_bad++;
         $display("FAIL rstmid_no_done: done seen=1 want 0");
      end
      a_reset = 1'b0;
      a_req1 = 1'b1;
      @(negedge clock);
      t0 = cyc;
      n_cmp++;
      if ({a_gnt0, a_gnt1} !== 2'b01) begin
         n_bad++;
         $display("FAIL rstmid_regrant: gnt0,gnt1 got %b want 01", {a_gnt0, a_gnt1});
      end
      a_req1 = 1'b0;
      wait_sig(3, 20, seen);
      n_cmp++;
      if (!seen || (cyc - t0) != A_S || a_result !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_complete: done1=%0d lat=%0d result=%b want 1 %0d 1", seen, cyc - t0, a_result, A_S);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ta [4];
      logic [3:0] tb [4];
      logic [3:0] exp;
      bit         seen;
      int         t0;
      ta = '{4'hC, 4'hF, 4'h3, 4'h5};
      tb = '{4'hA, 4'hA, 4'h6, 4'hF};
      b_op0_a = ta[0]; b_op0_b = tb[0]; b_req0 = 1'b1;
      wait_sig(4, 5, seen);
      t0 = cyc;
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL b2b_first_gnt: gnt0 got 0 want 1");
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({b_gnt0, b_done0, b_busy, b_in1, b_in2} !== {3'b101, ta[i], tb[i]}) begin
            n_bad++;
            $display("FAIL b2b_grant%0d: got %h want %h", i,
                     {b_gnt0, b_done0, b_busy, b_in1, b_in2}, {3'b101, ta[i], tb[i]});
         end
         if (i == 3) b_req0 = 1'b0;
         @(negedge clock);
         exp = ta[i] & tb[i];
         n_cmp++;
         if ({b_gnt0, b_done0, b_busy, b_result} !== {3'b010, exp}) begin
            n_bad++;
            $display("FAIL b2b_done%0d: gnt0,done0,busy,result got %h want %h", i,
                     {b_gnt0, b_done0, b_busy, b_result}, {3'b010, exp});
         end
         if (i < 3) begin
            b_op0_a = ta[i+1]; b_op0_b = tb[i+1];
            @(negedge clock);
            n_cmp++;
            if ((cyc - t0) != 2 * (i + 1)) begin
               n_bad++;
               $display("FAIL b2b_period%0d: got %0d want %0d", i, cyc - t0, 2 * (i + 1));
            end
         end
      end
      @(negedge clock);
      n_cmp++;
      if ({b_gnt0, b_busy, b_result} !== {2'b00, 4'h5}) begin
         n_bad++;
         $display("FAIL b2b_idle: gnt0,busy,result got %h want 05", {b_gnt0, b_busy, b_result});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time got limit want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_operand_change();
      test_contention();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
